// File: rtl/rf2p_ctrl_wrapper.sv
// ---------------------------------------------------------------------------
// rf2p_ctrl_wrapper
//
// Two-port register-file wrapper: one write port and one read port per cycle,
// byte-enabled writes, write-first read-during-write behaviour, an optional
// extra read-output register, and a zero-fill sequence that runs after reset
// and whenever the clear request in ram_ctrl rises.
//
// Ports:
//   clk          single clock, all logic on the rising edge
//   rst          asynchronous active-high reset
//   we_i         write request
//   wr_addr_i    write address (AW bits)
//   wdata_i      write data (DW bits)
//   wbe_i        byte enables, bit k covers wdata_i[8k+7:8k]
//   re_i         read request
//   rd_addr_i    read address (AW bits)
//   ram_rdata_o  read data, held between read results
//   rvalid_o     one-cycle pulse marking ram_rdata_o as fresh
//   busy_o       high while the zero-fill runs; requests are ignored then
//   ram_ctrl     [5:0] macro timing trims, [6] clear request
//   tsel_o       registered copy of ram_ctrl[5:0]
// ---------------------------------------------------------------------------
module rf2p_ctrl_wrapper #(
  parameter int DW             = 32,
  parameter int AW             = 6,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic [DW/8-1:0] wbe_i,
  input  logic            re_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic [DW-1:0]   ram_rdata_o,
  output logic            rvalid_o,
  output logic            busy_o,
  input  logic [6:0]      ram_ctrl,
  output logic [5:0]      tsel_o
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t        state;
  logic          busy_q;
  logic [AW:0]   clr_cnt;
  logic [AW:0]   clr_cnt_nxt;
  logic          clr_req_q;
  logic          clr_edge;
  logic [5:0]    tsel_q;

  logic [DW-1:0] mem [DEPTH];

  logic          rd_accept;
  logic          wr_accept;
  logic [DW-1:0] rd_merge;

  logic [DW-1:0] s1_data;
  logic          s1_valid;

  // The clear request is compared against its value from the previous cycle,
  // so a level held high fires only once. The previous value keeps tracking
  // during CLEAR, which is what makes edges inside a clear get swallowed.
  assign clr_edge    = ram_ctrl[6] & ~clr_req_q;
  assign clr_cnt_nxt = clr_cnt + 1'b1;

  assign rd_accept = (state == READY) && re_i;
  assign wr_accept = (state == READY) && we_i;

  assign busy_o = busy_q;
  assign tsel_o = tsel_q;

  // Control FSM. CLEAR walks the counter from 0 to DEPTH-1, one address per
  // cycle; the carry into the extra counter bit marks the last address, so
  // READY follows on the next edge and CLEAR lasts exactly DEPTH cycles.
  // busy_q is kept as its own flop mirroring the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      busy_q    <= (CLEAR_ON_RESET != 0);
      clr_cnt   <= '0;
      clr_req_q <= 1'b0;
      tsel_q    <= '0;
    end else begin
      clr_req_q <= ram_ctrl[6];
      tsel_q    <= ram_ctrl[5:0];
      case (state)
        CLEAR: begin
          if (clr_cnt_nxt[AW]) begin
            state   <= READY;
            busy_q  <= 1'b0;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt_nxt;
          end
        end
        READY: begin
          if (clr_edge) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            clr_cnt <= '0;
          end
        end
        default: begin
          state  <= READY;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Storage array. It has no reset of its own; the only way its contents
  // get zeroed is the CLEAR walk. Writes are suppressed while rst is held so
  // the array is left alone during reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_cnt[AW-1:0]] <= '0;
      end else if (wr_accept) begin
        for (int k = 0; k < NB; k++) begin
          if (wbe_i[k]) begin
            mem[wr_addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
          end
        end
      end
    end
  end

  // Write-first bypass: when the read and an accepted write hit the same
  // address in the same cycle, the enabled bytes come from wdata_i and the
  // remaining bytes from the stored word.
  always_comb begin
    rd_merge = mem[rd_addr_i];
    if (wr_accept && (wr_addr_i == rd_addr_i)) begin
      for (int k = 0; k < NB; k++) begin
        if (wbe_i[k]) begin
          rd_merge[8*k +: 8] = wdata_i[8*k +: 8];
        end
      end
    end
  end

  // First read stage. Data only updates on an accepted read so it holds its
  // last value otherwise; the valid bit is a single-cycle pulse per read.
  // A read accepted in the cycle a clear is triggered still completes here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) begin
        s1_data <= rd_merge;
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] out_data;
      logic          out_valid;

      // Optional second stage: copies the first stage forward one cycle,
      // again holding the data between results.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_data  <= '0;
          out_valid <= 1'b0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_data <= s1_data;
          end
        end
      end

      assign ram_rdata_o = out_data;
      assign rvalid_o    = out_valid;
    end else begin : g_no_out_reg
      assign ram_rdata_o = s1_data;
      assign rvalid_o    = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_rf2p_ctrl_wrapper.sv
// ---------------------------------------------------------------------------
// tb_rf2p_ctrl_wrapper
//
// Drives two copies of rf2p_ctrl_wrapper from the same stimulus: one with
// OUT_REG=0 (suffix 0) and one with OUT_REG=1 (suffix 1). The registered copy
// is expected to show every read result exactly one cycle after the other.
// ---------------------------------------------------------------------------
module tb_rf2p_ctrl_wrapper;

  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we_i;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wdata_i;
  logic [3:0]    wbe_i;
  logic          re_i;
  logic [AW-1:0] rd_addr_i;
  logic [6:0]    ram_ctrl;

  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          busy0, busy1;
  logic [5:0]    tsel0, tsel1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic [3:0]    wbe;
    logic          re;
    logic [AW-1:0] ra;
    logic          ev;
    logic [31:0]   ed;
  } vec_t;

  vec_t vecs[$];

  rf2p_ctrl_wrapper #(.DW(DW), .AW(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst(rst), .we_i(we_i), .wr_addr_i(wr_addr_i), .wdata_i(wdata_i),
    .wbe_i(wbe_i), .re_i(re_i), .rd_addr_i(rd_addr_i), .ram_rdata_o(rdata0),
    .rvalid_o(rvalid0), .busy_o(busy0), .ram_ctrl(ram_ctrl), .tsel_o(tsel0)
  );

  rf2p_ctrl_wrapper #(.DW(DW), .AW(AW), .OUT_REG(1), .CLEAR_ON_RESET(1)) dut_r (
    .clk(clk), .rst(rst), .we_i(we_i), .wr_addr_i(wr_addr_i), .wdata_i(wdata_i),
    .wbe_i(wbe_i), .re_i(re_i), .rd_addr_i(rd_addr_i), .ram_rdata_o(rdata1),
    .rvalid_o(rvalid1), .busy_o(busy1), .ram_ctrl(ram_ctrl), .tsel_o(tsel1)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd,
                              input int wbe, input int re, input int ra,
                              input int ev, input logic [31:0] ed);
    vec_t v;
    v.we  = 1'(we);
    v.wa  = AW'(wa);
    v.wd  = wd;
    v.wbe = 4'(wbe);
    v.re  = 1'(re);
    v.ra  = AW'(ra);
    v.ev  = 1'(ev);
    v.ed  = ed;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    we_i      = v.we;
    wr_addr_i = v.wa;
    wdata_i   = v.wd;
    wbe_i     = v.wbe;
    re_i      = v.re;
    rd_addr_i = v.ra;
  endtask

  task automatic doRead(input int addr, input logic [31:0] exp, input string name);
    re_i      = 1'b1;
    rd_addr_i = AW'(addr);
    step();
    re_i = 1'b0;
    checkOutput({name, " rvalid"}, 32'(rvalid0), 32'd1);
    checkOutput({name, " data"}, rdata0, exp);
    step();
    checkOutput({name, " rvalid outreg"}, 32'(rvalid1), 32'd1);
    checkOutput({name, " data outreg"}, rdata1, exp);
  endtask

  initial begin
    int n;
    int p0;
    int p1;

    we_i      = 1'b0;
    wr_addr_i = '0;
    wdata_i   = '0;
    wbe_i     = '0;
    re_i      = 1'b0;
    rd_addr_i = '0;
    ram_ctrl  = 7'h2D;

    // Reset values and the post-reset clear length
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rdata", rdata0, 32'h0);
    checkOutput("reset rvalid", 32'(rvalid0), 32'd0);
    checkOutput("reset busy", 32'(busy0), 32'd1);
    checkOutput("reset tsel", 32'(tsel0), 32'd0);
    checkOutput("reset busy outreg", 32'(busy1), 32'd1);
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      step();
      n++;
    end
    checkOutput("initial clear cycles", 32'(n), 32'd64);
    checkOutput("initial clear done outreg", 32'(busy1), 32'd0);
    checkOutput("tsel copy", 32'(tsel0), 32'h2D);

    // Directed vectors; expected data is the held value when no read is due
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 0, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 17, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 63, 1, 32'h0));
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 'hF, 0, 0, 0, 32'h0));
    vecs.push_back(mk(1, 5, 32'h0000AA00, 'h2, 0, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 5, 1, 32'hDEADAAEF));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'hDEADAAEF));
    vecs.push_back(mk(1, 9, 32'hFFFFFFFF, 'hF, 0, 0, 0, 32'hDEADAAEF));
    vecs.push_back(mk(1, 9, 32'h12345678, 'h3, 1, 9, 1, 32'hFFFF5678));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 9, 1, 32'hFFFF5678));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(1, k, 32'(k * 3), 'hF, 0, 0, 0, 32'hFFFF5678));
    for (int k = 0; k < 8; k++)
      vecs.push_back(mk(0, 0, 32'h0, 0, 1, k, 1, 32'(k * 3)));
    vecs.push_back(mk(1, 5, 32'hFFFFFFFF, 'h0, 0, 0, 0, 32'd21));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 5, 1, 32'h0000000F));
    vecs.push_back(mk(1, 63, 32'hA5A5A5A5, 'hF, 1, 63, 1, 32'hA5A5A5A5));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 62, 1, 32'h0));
    vecs.push_back(mk(1, 62, 32'h00C30000, 'h4, 1, 61, 1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 62, 1, 32'h00C30000));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("v%0d rvalid", i), 32'(rvalid0), 32'(vecs[i].ev));
      checkOutput($sformatf("v%0d data", i), rdata0, vecs[i].ed);
      if (i > 0) begin
        checkOutput($sformatf("v%0d rvalid outreg", i - 1), 32'(rvalid1), 32'(vecs[i-1].ev));
        checkOutput($sformatf("v%0d data outreg", i - 1), rdata1, vecs[i-1].ed);
      end
    end
    applyStimulus(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0));
    step();
    checkOutput("last rvalid outreg", 32'(rvalid1), 32'(vecs[vecs.size()-1].ev));
    checkOutput("last data outreg", rdata1, vecs[vecs.size()-1].ed);
    checkOutput("idle rvalid", 32'(rvalid0), 32'd0);

    // Clear request with write and read held high throughout
    ram_ctrl[6] = 1'b1;
    we_i        = 1'b1;
    wr_addr_i   = AW'(20);
    wdata_i     = 32'h11111111;
    wbe_i       = 4'hF;
    re_i        = 1'b1;
    rd_addr_i   = AW'(9);
    step();
    checkOutput("trigger busy", 32'(busy0), 32'd1);
    checkOutput("trigger busy outreg", 32'(busy1), 32'd1);
    checkOutput("trigger read data", rdata0, 32'hFFFF5678);
    n  = 0;
    p0 = 0;
    p1 = 0;
    while (busy0 && n < 200) begin
      n++;
      p0 = p0 + int'(rvalid0);
      p1 = p1 + int'(rvalid1);
      step();
    end
    we_i = 1'b0;
    re_i = 1'b0;
    checkOutput("request clear cycles", 32'(n), 32'd64);
    checkOutput("pulses during clear", 32'(p0), 32'd1);
    checkOutput("pulses during clear outreg", 32'(p1), 32'd1);
    checkOutput("request clear done outreg", 32'(busy1), 32'd0);
    repeat (3) step();
    checkOutput("held request no retrigger", 32'(busy0), 32'd0);
    doRead(20, 32'h0, "cleared addr 20");
    doRead(9, 32'h0, "cleared addr 9");
    doRead(63, 32'h0, "cleared addr 63");
    doRead(0, 32'h0, "cleared addr 0");

    // Reset pulse in the middle of a clear
    we_i      = 1'b1;
    wr_addr_i = AW'(40);
    wdata_i   = 32'hCAFEF00D;
    wbe_i     = 4'hF;
    step();
    we_i = 1'b0;
    doRead(40, 32'hCAFEF00D, "addr 40 before clear");
    ram_ctrl[6] = 1'b0;
    step();
    ram_ctrl[6] = 1'b1;
    step();
    checkOutput("second trigger busy", 32'(busy0), 32'd1);
    repeat (30) step();
    rst = 1'b1;
    #1;
    checkOutput("mid-clear reset rdata", rdata0, 32'h0);
    checkOutput("mid-clear reset rdata outreg", rdata1, 32'h0);
    checkOutput("mid-clear reset rvalid", 32'(rvalid0), 32'd0);
    checkOutput("mid-clear reset tsel", 32'(tsel0), 32'd0);
    checkOutput("mid-clear reset busy", 32'(busy0), 32'd1);
    step();
    rst = 1'b0;
    n = 0;
    while (busy0 && n < 200) begin
      step();
      n++;
    end
    checkOutput("restarted clear cycles", 32'(n), 32'd64);
    checkOutput("tsel after reset", 32'(tsel0), 32'h2D);
    doRead(40, 32'h0, "addr 40 after clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf2p_ctrl_wrapper.md
RF2P_CTRL_WRAPPER -- requirements
Module: rf2p_ctrl_wrapper

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits (multiple of 8).
REQ-002 SHALL have parameter AW, default 6, address width; depth = 2**AW.
REQ-003 SHALL have parameter OUT_REG, default 0, adds one read-output register stage when 1.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, runs zero-fill of all entries after reset when 1.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port we_i  input  1  write request.
REQ-008 SHALL have port wr_addr_i  input  AW  write address.
REQ-009 SHALL have port wdata_i  input  DW  write data.
REQ-010 SHALL have port wbe_i  input  DW/8  byte enables; bit k covers wdata_i[8k+7:8k].
REQ-011 SHALL have port re_i  input  1  read request.
REQ-012 SHALL have port rd_addr_i  input  AW  read address.
REQ-013 SHALL have port ram_rdata_o  output  DW  read data.
REQ-014 SHALL have port rvalid_o  output  1  one-cycle pulse, ram_rdata_o valid.
REQ-015 SHALL have port busy_o  output  1  clear sequence in progress; requests ignored.
REQ-016 SHALL have port ram_ctrl  input  7  [5:0] macro timing trims, [6] clear request.
REQ-017 SHALL have port tsel_o  output  6  registered copy of ram_ctrl[5:0] (RTSEL=[1:0], WTSEL=[3:2], MTSEL=[5:4]).

Function
REQ-018 SHALL implement storage of 2**AW x DW with one independent write and one independent read per cycle.
REQ-019 SHALL, in READY with we_i=1, update only bytes with wbe_i[k]=1 at wr_addr_i on the clock edge; wbe_i=0 is a no-op.
REQ-020 SHALL, in READY with re_i=1, present data at rd_addr_i with rvalid_o=1 exactly 1 cycle later (OUT_REG=0) or 2 cycles later (OUT_REG=1).
REQ-021 SHALL, on same-cycle read and write to the same address, return write-first data: enabled bytes from wdata_i, others from stored word.
REQ-022 SHALL hold ram_rdata_o at its last value when rvalid_o=0.
REQ-023 SHALL accept back-to-back reads every cycle with one rvalid_o pulse per accepted read, in order.
REQ-024 SHALL implement FSM states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-025 SHALL, in CLEAR, write all-zero to addresses 0..2**AW-1 ascending, one per cycle, using an AW+1-bit counter; after address 2**AW-1 transition to READY next cycle.
REQ-026 SHALL assert busy_o=1 exactly while in CLEAR; CLEAR lasts 2**AW cycles.
REQ-027 SHALL ignore we_i and re_i while busy_o=1 (no write, no rvalid_o).
REQ-028 SHALL detect a 0->1 transition of ram_ctrl[6] (registered) in READY and enter CLEAR next cycle; level held high does not retrigger; edges during CLEAR are ignored.
REQ-029 SHALL complete any read accepted before entering CLEAR (rvalid_o still pulses).
REQ-030 SHALL register ram_ctrl[5:0] to tsel_o every cycle.

Reset
REQ-031 SHALL, on rst=1, asynchronously force ram_rdata_o=0, rvalid_o=0, tsel_o=0, clear counter=0, pipeline valids=0, busy_o=CLEAR_ON_RESET.
REQ-032 SHALL, on rst asserted mid-CLEAR, restart CLEAR from address 0 after release.
REQ-033 SHALL not reset storage contents except via the CLEAR sequence.

Verification
REQ-034 Reset release, AW=6, CLEAR_ON_RESET=1 -> busy_o high exactly 64 cycles; subsequent reads of addresses 0, 17, 63 return 0.
REQ-035 Write 0xDEADBEEF addr 5 wbe=0xF, then wbe=0x2 data 0x0000AA00 -> read addr 5 returns 0xDEADAAEF, rvalid_o at +1 (OUT_REG=0) and +2 (OUT_REG=1).
REQ-036 Same cycle write addr 9 = 0x12345678 wbe=0x3 over stored 0xFFFFFFFF with read addr 9 -> ram_rdata_o=0xFFFF5678.
REQ-037 Reads every cycle of addresses 0..7 after writing addr*3 -> 8 consecutive rvalid_o pulses, data 0,3,...,21 in order.
REQ-038 ram_ctrl[6] 0->1 in READY with we_i/re_i held high -> busy_o next cycle for 64 cycles, no writes/rvalid_o during, all entries 0 after.
REQ-039 rst pulse at clear address 30 -> outputs reset immediately; after release busy_o high full 64 cycles.
